rx_fifo_writer: RTL and testbench
=================================

// Module: rx_fifo_writer
// PURPOSE
// Write-domain front end of the RX clock-crossing path. Takes the byte stream from the RX
// datapath, frames it into {err,last,data} words and drives the afifo write port.
// A one-byte holding register lets the final byte carry the last flag.
// Frames are length- and error-checked; FIFO overflow truncates the frame with an error terminator.
// PARAMETERS
// MIN_LEN  64    minimum legal frame length in bytes; shorter frames get err=1
// MAX_LEN  1518  maximum legal frame length in bytes; longer frames get err=1
// CNT_W    16    width of the frame_cnt/drop_cnt statistics counters
// PORTS
// wclk        in   1      write-domain clock
// wrst        in   1      reset, synchronous, active-high; clock wclk
// rx_dv       in   1      byte valid; contiguous high cycles form one frame
// rx_data     in   8      frame byte, valid when rx_dv=1
// rx_er       in   1      PHY error flag for the current byte
// fifo_we     out  1      afifo write enable (combinational)
// fifo_wdata  out  10     {err,last,data[7:0]} to afifo (instantiated with WIDTH=10)
// fifo_wfull  in   1      afifo full flag
// frame_cnt   out  CNT_W  count of frames terminated with last=1, err=0; saturating
// drop_cnt    out  CNT_W  count of frames truncated or dropped on overflow; saturating
// busy        out  1      state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, hold empty, len=0, err_acc=0, counters=0, prev_dv=1.
//   fifo_we=0 whenever wrst=1. busy=0.
// - The write rule is fifo_we only when fifo_wfull=0. An attempted write while full counts as overflow.
// - The frame start is accepted only in IDLE, with rx_dv=1 and prev_dv=0. A frame already in progress
//   when reset releases is ignored until rx_dv goes low.
// - IDLE: on start, hold<=rx_data, len<=1, err_acc<=rx_er, and go to FRAME. No write in this cycle.
// - FRAME, rx_dv=1: write {0,0,hold}; hold<=rx_data; len+=1 (saturate at 16'hFFFF); err_acc|=rx_er.
//   - If full, the byte is lost: drop_cnt+=1 and go to DROP.
// - FRAME, rx_dv=0: write {E,1,hold}, where E = err_acc | (len<MIN_LEN) | (len>MAX_LEN).
//   - If the write succeeds and E=0: frame_cnt+=1. Go to IDLE.
//   - If full: drop_cnt+=1 and go to TERM.
// - DROP: discard all bytes. When rx_dv=0, go to TERM.
// - TERM: fifo_wdata={1,1,8'h00}, fifo_we=~fifo_wfull.
//   - If rx_dv=1, the byte is discarded, drop_cnt+=1, and the next state is DROP, even if the
//     terminator was written in this cycle.
//   - Else if written, go to IDLE. Else stay in TERM.
// - Latency: each byte is written 1 cycle after it is presented. The last byte is written in the
//   first rx_dv=0 cycle.
// - Every frame presented to the FIFO ends with exactly one last=1 word. A truncated frame ends
//   with err=1 and last=1.
// - A minimum of 1 rx_dv=0 cycle between frames is guaranteed by the IFG.
// - Counters hold at all-ones.
// - wrst mid-frame: abandon immediately with no terminator. The afifo shares wrst, so the partial
//   frame is flushed.
// TESTING
// 1. 64-byte frame 0x00..0x3F with no full: 64 writes, the first one cycle after the first rx_dv.
//    last=1 only on 0x3F with err=0. frame_cnt=1.
// 2. 10-byte frame: 10 writes. The last word has err=1 and last=1. frame_cnt stays 0.
//    Repeat with a 1519-byte frame: err=1.
// 3. 100-byte frame with rx_er on byte 5: all 100 written. The last word has err=1.
// 4. 100-byte frame, fifo_wfull high from the byte-19 write until 3 cycles after rx_dv falls:
//    bytes 0..18 written, drop_cnt=1. The single word {1,1,00} is written on the first cycle
//    fifo_wfull=0. Then IDLE.
// 5. As test 4, but a new frame starts while in TERM and full: it is fully discarded, drop_cnt=2,
//    and one terminator is written after that frame ends.
// 6. wrst pulsed at byte 30 with rx_dv held high: fifo_we=0 during reset and the counters clear.
//    Nothing is written until the next rx_dv 0->1 edge. That frame is written normally.

Source files
------------

// File: rtl/rx_fifo_writer_if.sv
// rx_fifo_writer_if: RX byte stream in, afifo write port out
interface rx_fifo_writer_if;
    logic       rx_dv;
    logic [7:0] rx_data;
    logic       rx_er;
    logic       fifo_we;
    logic [9:0] fifo_wdata;
    logic       fifo_wfull;
    modport master (input rx_dv, rx_data, rx_er, fifo_wfull, output fifo_we, fifo_wdata);
    modport slave  (output rx_dv, rx_data, rx_er, fifo_wfull, input fifo_we, fifo_wdata);
endinterface

// File: rtl/rx_fifo_writer.sv
// rx_fifo_writer: frames the RX byte stream into {err,last,data} afifo words
module rx_fifo_writer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             wclk,
    input  logic             wrst,
    rx_fifo_writer_if.master bus,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, FRAME, DROP, TERM} state_t;
    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);
    state_t      state, state_nx;
    logic [7:0]  hold, hold_nx;
    logic [15:0] len, len_nx;
    logic        err_acc, err_acc_nx;
    logic        prev_dv;
    logic        frame_inc, drop_inc, end_err;
    assign busy = state != IDLE;
    // State, holding register and saturating statistics; prev_dv resets high so a frame in flight at reset release is ignored
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state     <= IDLE;
            hold      <= 8'h00;
            len       <= 16'd0;
            err_acc   <= 1'b0;
            prev_dv   <= 1'b1;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            len       <= len_nx;
            err_acc   <= err_acc_nx;
            prev_dv   <= bus.rx_dv;
            frame_cnt <= frame_inc ? frame_cnt + CNT_W'(frame_cnt != '1) : frame_cnt;
            drop_cnt  <= drop_inc ? drop_cnt + CNT_W'(drop_cnt != '1) : drop_cnt;
        end
    end
    // Next state and FIFO write; the held byte goes out one cycle late so the final one can carry last
    always_comb begin
        end_err        = err_acc | (len < MIN_L) | (len > MAX_L);
        state_nx       = state;
        hold_nx        = hold;
        len_nx         = len;
        err_acc_nx     = err_acc;
        frame_inc      = 1'b0;
        drop_inc       = 1'b0;
        bus.fifo_we    = 1'b0;
        bus.fifo_wdata = 10'h000;
        case (state)
            IDLE: begin
                if (bus.rx_dv && !prev_dv) begin
                    state_nx   = FRAME;
                    hold_nx    = bus.rx_data;
                    len_nx     = 16'd1;
                    err_acc_nx = bus.rx_er;
                end
            end
            FRAME: begin
                bus.fifo_we    = !bus.fifo_wfull;
                bus.fifo_wdata = {end_err & !bus.rx_dv, !bus.rx_dv, hold};
                if (bus.rx_dv) begin
                    hold_nx    = bus.rx_data;
                    len_nx     = len + 16'(len != 16'hFFFF);
                    err_acc_nx = err_acc | bus.rx_er;
                    drop_inc   = bus.fifo_wfull;
                    state_nx   = bus.fifo_wfull ? DROP : FRAME;
                end else begin
                    drop_inc  = bus.fifo_wfull;
                    frame_inc = !bus.fifo_wfull && !end_err;
                    state_nx  = bus.fifo_wfull ? TERM : IDLE;
                end
            end
            DROP: state_nx = bus.rx_dv ? DROP : TERM;
            TERM: begin
                bus.fifo_we    = !bus.fifo_wfull;
                bus.fifo_wdata = 10'h300;
                drop_inc       = bus.rx_dv;
                state_nx       = bus.rx_dv ? DROP : (bus.fifo_wfull ? TERM : IDLE);
            end
            default: state_nx = IDLE;
        endcase
        if (wrst) bus.fifo_we = 1'b0;
    end
endmodule

// File: tb/tb_rx_fifo_writer.sv
// tb_rx_fifo_writer: directed frame vectors plus overflow and reset sequences
module tb_rx_fifo_writer;
    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [15:0] frame_cnt, drop_cnt;
    logic        busy;
    int          cyc = 0;
    int          n_run = 0;
    int          n_fail = 0;
    logic [9:0]  wq[$];
    int          wc[$];
    rx_fifo_writer_if bus();
    rx_fifo_writer #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut (
        .wclk(wclk), .wrst(wrst), .bus(bus),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );
    always #5 wclk = ~wclk;
    // Cycle index of the current clock period
    always @(posedge wclk) cyc <= cyc + 1;
    // Record every accepted FIFO write with its cycle
    always @(negedge wclk) begin
        if (bus.fifo_we) begin
            wq.push_back(bus.fifo_wdata);
            wc.push_back(cyc);
        end
    end
    typedef struct { int n; int er; logic e; int fc; } vec_t;
    vec_t vt[8];
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic step(input logic dv, input logic [7:0] d, input logic er, input logic full);
        bus.rx_dv = dv;
        bus.rx_data = d;
        bus.rx_er = er;
        bus.fifo_wfull = full;
        @(posedge wclk);
        #1;
    endtask
    task automatic clear_q();
        wq.delete();
        wc.delete();
    endtask
    task automatic run_frame(input int n, input int er_idx, output int start);
        start = cyc;
        for (int k = 0; k < n; k++) step(1'b1, 8'(k), k == er_idx, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask
    task automatic check_frame(input string nm, input int n, input logic e, input int start);
        int bad = 0;
        logic [9:0] w;
        check({nm, " count"}, wq.size(), n);
        for (int i = 0; i < wq.size(); i++) begin
            w = (i < n - 1) ? {2'b00, 8'(i)} : {e, 1'b1, 8'(n - 1)};
            if (wq[i] !== w || wc[i] != start + 1 + i) bad++;
        end
        check({nm, " body"}, bad, 0);
        if (wq.size() > 0) check({nm, " last"}, wq[wq.size() - 1], {e, 1'b1, 8'(n - 1)});
    endtask
    initial begin
        int start, bad;
        vt[0] = '{64, -1, 1'b0, 1};
        vt[1] = '{10, -1, 1'b1, 1};
        vt[2] = '{1519, -1, 1'b1, 1};
        vt[3] = '{100, 5, 1'b1, 1};
        vt[4] = '{1518, -1, 1'b0, 2};
        vt[5] = '{63, -1, 1'b1, 2};
        vt[6] = '{65, -1, 1'b0, 3};
        vt[7] = '{1, -1, 1'b1, 3};
        bus.rx_dv = 1'b1;
        bus.rx_data = 8'hA5;
        bus.rx_er = 1'b0;
        bus.fifo_wfull = 1'b0;
        @(posedge wclk);
        #1;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("reset we", bus.fifo_we, 0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        wrst = 1'b0;
        clear_q();
        for (int k = 0; k < 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
        check("reset busy", busy, 0);
        check("reset frame_cnt", frame_cnt, 0);
        check("reset drop_cnt", drop_cnt, 0);
        check("in-flight ignored", wq.size(), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            clear_q();
            run_frame(vt[v].n, vt[v].er, start);
            check_frame($sformatf("vec%0d", v), vt[v].n, vt[v].e, start);
            check($sformatf("vec%0d frame_cnt", v), frame_cnt, vt[v].fc);
            check($sformatf("vec%0d busy", v), busy, 0);
        end
        check("no drops", drop_cnt, 0);
        clear_q();
        start = cyc;
        for (int k = 0; k < 106; k++) step(k < 100, 8'(k), 1'b0, k >= 20 && k < 103);
        check("ovf count", wq.size(), 20);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] !== ((i < 19) ? {2'b00, 8'(i)} : 10'h300) || wc[i] != ((i < 19) ? start + 1 + i : start + 103)) bad++;
        check("ovf body", bad, 0);
        check("ovf drop_cnt", drop_cnt, 1);
        check("ovf frame_cnt", frame_cnt, 3);
        check("ovf busy", busy, 0);
        clear_q();
        start = cyc;
        for (int k = 0; k < 126; k++) step(k < 100 || (k >= 102 && k < 122), 8'(k), 1'b0, k >= 20 && k < 110);
        check("term-restart count", wq.size(), 20);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] !== ((i < 19) ? {2'b00, 8'(i)} : 10'h300) || wc[i] != ((i < 19) ? start + 1 + i : start + 123)) bad++;
        check("term-restart body", bad, 0);
        check("term-restart drop_cnt", drop_cnt, 3);
        check("term-restart busy", busy, 0);
        clear_q();
        for (int k = 0; k < 30; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
        wrst = 1'b1;
        bus.rx_dv = 1'b1;
        bus.rx_data = 8'd30;
        #3;
        check("wrst we", bus.fifo_we, 0);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        check("mid-frame writes", wq.size(), 29);
        clear_q();
        check("wrst frame_cnt", frame_cnt, 0);
        check("wrst drop_cnt", drop_cnt, 0);
        check("wrst busy", busy, 0);
        for (int k = 31; k < 64; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("post-wrst silent", wq.size(), 0);
        clear_q();
        run_frame(64, -1, start);
        check_frame("post-wrst frame", 64, 1'b0, start);
        check("post-wrst frame_cnt", frame_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
